// File: rtl/host_rr_arbiter.sv
// host_rr_arbiter
//   Shares one req/gnt/rvalid bus host port among NrReq requesters with
//   round-robin fairness. At most one transaction is outstanding. A response
//   timeout makes sure every granted requester receives exactly one response.
//
// Ports
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   req_i / gnt_o         : per-requester request / grant
//   addr_i, we_i, be_i,
//   wdata_i               : per-requester payload
//   rvalid_o              : per-requester response valid (one-cycle pulse)
//   rdata_o, err_o        : shared response data / error
//   bus_req_o, bus_gnt_i  : bus request / grant
//   bus_addr_o, bus_we_o,
//   bus_be_o, bus_wdata_o : bus payload, zero whenever bus_req_o is low
//   bus_rvalid_i, bus_rdata_i,
//   bus_err_i             : bus response
module host_rr_arbiter #(
    parameter int NrReq         = 3,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NrReq-1:0]                     req_i,
    output logic [NrReq-1:0]                     gnt_o,
    input  logic [NrReq-1:0][AddressWidth-1:0]   addr_i,
    input  logic [NrReq-1:0]                     we_i,
    input  logic [NrReq-1:0][3:0]                be_i,
    input  logic [NrReq-1:0][DataWidth-1:0]      wdata_i,
    output logic [NrReq-1:0]                     rvalid_o,
    output logic [DataWidth-1:0]                 rdata_o,
    output logic                                 err_o,
    output logic                                 bus_req_o,
    input  logic                                 bus_gnt_i,
    output logic [AddressWidth-1:0]              bus_addr_o,
    output logic                                 bus_we_o,
    output logic [3:0]                           bus_be_o,
    output logic [DataWidth-1:0]                 bus_wdata_o,
    input  logic                                 bus_rvalid_i,
    input  logic [DataWidth-1:0]                 bus_rdata_i,
    input  logic                                 bus_err_i
);

    localparam int IdxW = $clog2(NrReq);
    localparam int CntW = $clog2(TimeoutCycles + 1);
    // Counter is 0 in the first RESP cycle, so it holds TimeoutCycles-1 in
    // the cycle that lies TimeoutCycles cycles after the grant edge.
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   sel_q, sel_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              any_req;
    logic [IdxW-1:0]   win_idx;
    logic              win_found;
    logic [IdxW-1:0]   cand_idx;
    logic [IdxW-1:0]   cur_sel;
    logic              bus_grant;
    logic              timeout;
    logic              resp_fire;

    assign any_req = |req_i;

    // Round-robin search starting one past the previous winner.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand_idx  = '0;
        if (state_q == IDLE) begin
            for (int off = 1; off <= NrReq; off++) begin
                cand_idx = IdxW'((int'(last_q) + off) % NrReq);
                if (!win_found && req_i[cand_idx]) begin
                    win_found = 1'b1;
                    win_idx   = cand_idx;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= IdxW'(NrReq - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_d   = win_idx;
                    state_d = bus_gnt_i ? RESP : ADDR;
                end
            end
            ADDR: begin
                if (bus_gnt_i) state_d = RESP;
            end
            RESP: begin
                if (resp_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus_grant) begin
            last_d = cur_sel;
            cnt_d  = '0;
        end else if (state_q == RESP && cnt_q != {CntW{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output logic.
    always_comb begin
        cur_sel = (state_q == IDLE) ? win_idx : sel_q;
        // Gated by rst_ni so the bus stays quiet while reset is held even if
        // requesters are already asserting req_i.
        bus_req_o = rst_ni &&
                    ((state_q == IDLE && any_req) || state_q == ADDR);
        bus_grant = bus_gnt_i & bus_req_o;

        bus_addr_o  = '0;
        bus_we_o    = 1'b0;
        bus_be_o    = '0;
        bus_wdata_o = '0;
        if (bus_req_o) begin
            bus_addr_o  = addr_i[cur_sel];
            bus_we_o    = we_i[cur_sel];
            bus_be_o    = be_i[cur_sel];
            bus_wdata_o = wdata_i[cur_sel];
        end

        // A real response wins over a timeout hitting in the same cycle.
        timeout   = (state_q == RESP) && (cnt_q == CntLast) && !bus_rvalid_i;
        resp_fire = (state_q == RESP) && (bus_rvalid_i || timeout);

        rdata_o = '0;
        err_o   = 1'b0;
        if (state_q == RESP && bus_rvalid_i) begin
            rdata_o = bus_rdata_i;
            err_o   = bus_err_i;
        end else if (timeout) begin
            err_o   = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NrReq; gi++) begin : g_req
            assign gnt_o[gi]    = bus_grant & (cur_sel == IdxW'(gi));
            assign rvalid_o[gi] = resp_fire & (sel_q == IdxW'(gi));
        end
    endgenerate

    always @(posedge clk_i) begin
        if (rst_ni) begin
            a_sel_in_range: assert (int'(sel_q) < NrReq);
        end
    end

endmodule

// File: tb/tb_host_rr_arbiter.sv
// Directed testbench for host_rr_arbiter (NrReq=3, TimeoutCycles=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the falling edge.
module tb_host_rr_arbiter;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [2:0]        req_i;
    logic [2:0]        gnt_o;
    logic [2:0][31:0]  addr_i;
    logic [2:0]        we_i;
    logic [2:0][3:0]   be_i;
    logic [2:0][31:0]  wdata_i;
    logic [2:0]        rvalid_o;
    logic [31:0]       rdata_o;
    logic              err_o;
    logic              bus_req_o;
    logic              bus_gnt_i;
    logic [31:0]       bus_addr_o;
    logic              bus_we_o;
    logic [3:0]        bus_be_o;
    logic [31:0]       bus_wdata_o;
    logic              bus_rvalid_i;
    logic [31:0]       bus_rdata_i;
    logic              bus_err_i;

    int n_checks = 0;
    int n_pass   = 0;

    host_rr_arbiter #(
        .NrReq         (3),
        .DataWidth     (32),
        .AddressWidth  (32),
        .TimeoutCycles (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .bus_req_o    (bus_req_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_addr_o   (bus_addr_o),
        .bus_we_o     (bus_we_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_i    (bus_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %s: %0h", tag, obs);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [2:0] exp_oh;

        rst_ni       = 1'b0;
        req_i        = 3'b001;
        addr_i       = '0;
        we_i         = '0;
        be_i         = '0;
        wdata_i      = '0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h5555_AAAA;
        bus_err_i    = 1'b1;
        addr_i[0]    = 32'h0000_0100;

        // Reset values while inputs are active.
        #12;
        check("rst_gnt",      gnt_o,       3'b000);
        check("rst_rvalid",   rvalid_o,    3'b000);
        check("rst_rdata",    rdata_o,     32'h0);
        check("rst_err",      err_o,       1'b0);
        check("rst_bus_req",  bus_req_o,   1'b0);
        check("rst_bus_addr", bus_addr_o,  32'h0);
        check("rst_bus_misc", {bus_we_o, bus_be_o, bus_wdata_o}, 37'h0);
        req_i        = '0;
        bus_rvalid_i = 1'b0;
        bus_err_i    = 1'b0;
        rst_ni       = 1'b1;

        // Single read from requester 1, answered one cycle after grant.
        step();
        req_i     = 3'b010;
        addr_i[1] = 32'h8000_1000;
        be_i[1]   = 4'hF;
        we_i[1]   = 1'b0;
        bus_gnt_i = 1'b1;
        #4;
        check("rd_bus_req",  bus_req_o,  1'b1);
        check("rd_bus_addr", bus_addr_o, 32'h8000_1000);
        check("rd_bus_be",   bus_be_o,   4'hF);
        check("rd_gnt",      gnt_o,      3'b010);
        step();
        req_i        = '0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hDEAD_BEEF;
        bus_err_i    = 1'b0;
        #4;
        check("rd_rvalid",   rvalid_o,  3'b010);
        check("rd_rdata",    rdata_o,   32'hDEAD_BEEF);
        check("rd_err",      err_o,     1'b0);
        check("rd_resp_req", bus_req_o, 1'b0);
        step();
        bus_rvalid_i = 1'b0;
        #4;
        check("rd_rvalid_end", rvalid_o, 3'b000);

        // Timeout: requester 0 granted, device never answers.
        step();
        req_i     = 3'b001;
        addr_i[0] = 32'h1000_0040;
        bus_gnt_i = 1'b1;
        #4;
        check("to_gnt", gnt_o, 3'b001);
        step();
        req_i       = '0;
        bus_gnt_i   = 1'b0;
        bus_rdata_i = 32'h1234_5678;
        for (int c = 1; c <= 7; c++) begin
            #4;
            check($sformatf("to_wait%0d", c), rvalid_o, 3'b000);
            step();
        end
        #4;
        check("to_rvalid", rvalid_o, 3'b001);
        check("to_err",    err_o,    1'b1);
        check("to_rdata",  rdata_o,  32'h0);
        step();
        step();
        step();
        bus_rvalid_i = 1'b1;
        #4;
        check("late_rvalid", rvalid_o, 3'b000);
        check("late_err",    err_o,    1'b0);
        step();
        bus_rvalid_i = 1'b0;

        // Error passthrough: last winner 0, so requester 1 wins now.
        req_i     = 3'b010;
        bus_gnt_i = 1'b1;
        #4;
        check("ep_gnt", gnt_o, 3'b010);
        step();
        req_i        = '0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_err_i    = 1'b1;
        bus_rdata_i  = 32'h0BAD_0BAD;
        #4;
        check("ep_rvalid", rvalid_o, 3'b010);
        check("ep_err",    err_o,    1'b1);
        check("ep_rdata",  rdata_o,  32'h0BAD_0BAD);
        step();
        bus_rvalid_i = 1'b0;
        bus_err_i    = 1'b0;

        // Reset while waiting in RESP (requester 2 granted).
        req_i     = 3'b100;
        bus_gnt_i = 1'b1;
        #4;
        check("rr_gnt", gnt_o, 3'b100);
        step();
        req_i     = '0;
        bus_gnt_i = 1'b0;
        step();
        step();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hCAFE_F00D;
        req_i        = 3'b111;
        bus_gnt_i    = 1'b1;
        #2;
        check("rr_rvalid_pre", rvalid_o, 3'b100);
        rst_ni = 1'b0;
        #1;
        check("rr_rvalid", rvalid_o,  3'b000);
        check("rr_rdata",  rdata_o,   32'h0);
        check("rr_busreq", bus_req_o, 1'b0);
        check("rr_gnt_rst", gnt_o,    3'b000);
        bus_rvalid_i = 1'b0;
        step();
        rst_ni = 1'b1;

        // Fairness: all three requesting, order must restart at index 0.
        for (int t = 0; t < 6; t++) begin
            exp_oh       = 3'b001 << (t % 3);
            bus_gnt_i    = 1'b1;
            bus_rvalid_i = 1'b0;
            #4;
            check($sformatf("fair_gnt%0d", t), gnt_o, exp_oh);
            step();
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = 32'(t);
            #4;
            check($sformatf("fair_rv%0d", t), rvalid_o, exp_oh);
            step();
        end
        req_i        = '0;
        bus_rvalid_i = 1'b0;

        // Delayed grant: requester 1 wins, requester 2 joins during ADDR.
        addr_i[1]  = 32'h2000_0010;
        addr_i[2]  = 32'h3000_0020;
        wdata_i[1] = 32'h1111_1111;
        wdata_i[2] = 32'h2222_2222;
        we_i[1]    = 1'b1;
        req_i      = 3'b010;
        bus_gnt_i  = 1'b0;
        #4;
        check("dg_idle_addr", bus_addr_o, 32'h2000_0010);
        check("dg_idle_gnt",  gnt_o,      3'b000);
        step();
        req_i = 3'b110;
        for (int c = 1; c <= 3; c++) begin
            #4;
            check($sformatf("dg_addr%0d", c), bus_addr_o, 32'h2000_0010);
            check($sformatf("dg_nognt%0d", c), gnt_o, 3'b000);
            step();
        end
        bus_gnt_i = 1'b1;
        #4;
        check("dg_gnt",   gnt_o,       3'b010);
        check("dg_wdata", bus_wdata_o, 32'h1111_1111);
        check("dg_we",    bus_we_o,    1'b1);
        step();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        #4;
        check("dg_rvalid", rvalid_o, 3'b010);
        step();
        bus_rvalid_i = 1'b0;
        bus_gnt_i    = 1'b1;
        #4;
        check("dg_next_gnt",  gnt_o,      3'b100);
        check("dg_next_addr", bus_addr_o, 32'h3000_0020);
        step();
        req_i        = '0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        #4;
        check("dg_next_rv", rvalid_o, 3'b100);
        step();
        bus_rvalid_i = 1'b0;
        #10;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/host_rr_arbiter.md
# host_rr_arbiter

Round-robin arbiter that shares one bus host port among `NrReq` requesters, for example a DMA engine, the debug SBA master and a future accelerator. It sits between those requesters and a single `host_*` slot of the system bus. The bus interface is req/gnt/rvalid with at most one transaction outstanding. A response timeout guarantees every granted requester receives exactly one response, even when the downstream device never answers.

## Interface
Parameters:
- `NrReq`, default 3: number of requesters, 2..8.
- `DataWidth`, default 32: width of wdata and rdata.
- `AddressWidth`, default 32: address width.
- `TimeoutCycles`, default 255: maximum wait for `bus_rvalid_i` after a grant, 1..65535.

Ports:
- `clk_i` in 1: system clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_i` in `[NrReq]`: requester request.
- `gnt_o` out `[NrReq]`: requester grant.
- `addr_i` in `[NrReq]` × AddressWidth: requester address.
- `we_i` in `[NrReq]`: requester write enable.
- `be_i` in `[NrReq]` × 4: requester byte enables.
- `wdata_i` in `[NrReq]` × DataWidth: requester write data.
- `rvalid_o` out `[NrReq]`: response valid.
- `rdata_o` out DataWidth: response data, shared by all requesters.
- `err_o` out 1: response error, shared by all requesters.
- `bus_req_o` out 1: bus request.
- `bus_gnt_i` in 1: bus grant.
- `bus_addr_o` out AddressWidth: bus address.
- `bus_we_o` out 1: bus write enable.
- `bus_be_o` out 4: bus byte enables.
- `bus_wdata_o` out DataWidth: bus write data.
- `bus_rvalid_i` in 1: bus response valid.
- `bus_rdata_i` in DataWidth: bus response data.
- `bus_err_i` in 1: bus response error.

## Operation
- FSM states are IDLE, ADDR and RESP. Reset state is IDLE.
- Arbitration:
  - Round-robin on `req_i`. The search starts at `last_q+1` modulo NrReq, where `last_q` is the index of the previous winner.
  - The reset value of `last_q` is NrReq-1, so index 0 has priority first.
  - The winner is computed combinationally only in IDLE.
- IDLE:
  - If any `req_i` is set, drive `bus_*` from the winner and register the winner into `sel_q`.
  - If `bus_gnt_i` is high in the same cycle, go to RESP. Otherwise go to ADDR.
- ADDR:
  - Drive `bus_*` from `sel_q`, with no re-arbitration.
  - The requester must hold its `req_i` and payload until granted, per bus protocol.
  - On `bus_gnt_i`, go to RESP.
- Grant:
  - `gnt_o[k] = bus_gnt_i & bus_req_o & (k == current selection)`.
  - `last_q` updates to the current selection on grant.
- RESP:
  - `bus_req_o` is 0. A cycle counter starts at 0 on the grant edge and increments each RESP cycle.
  - On `bus_rvalid_i`: pulse `rvalid_o[sel_q]`, pass through `rdata_o=bus_rdata_i` and `err_o=bus_err_i` in the same cycle, then go to IDLE.
  - On timeout (counter reaches TimeoutCycles without rvalid): pulse `rvalid_o[sel_q]` with `err_o=1` and `rdata_o=0`, then go to IDLE.
- A `bus_rvalid_i` that arrives outside RESP is dropped. No `rvalid_o` bit is asserted for it.
- `req_i` deasserted in ADDR violates the protocol. The arbiter keeps requesting from `sel_q` regardless; it does not abort.
- Out-of-range selection is impossible; the assertion `sel_q < NrReq` is checked.
- Asynchronous reset mid-transaction returns to IDLE immediately. Any pending response is lost.

## Timing
- Output reset values:
  - `gnt_o` = 0.
  - `rvalid_o` = 0.
  - `rdata_o` = 0.
  - `err_o` = 0.
  - `bus_req_o` = 0.
  - `bus_addr_o`, `bus_we_o`, `bus_be_o`, `bus_wdata_o` = 0, because they are driven to 0 whenever `bus_req_o` is 0.
- Request to bus: `bus_req_o` asserts in the same cycle as `req_i` when in IDLE. The arbiter adds zero latency.
- Back-to-back throughput: at most one transaction per 2 cycles, for the grant and then an rvalid one cycle later. The next request can be issued in the cycle after the rvalid.
- Response to requester: `rvalid_o` is combinational from `bus_rvalid_i` and lasts exactly 1 cycle.
- Timeout response: `rvalid_o` appears TimeoutCycles cycles after the grant edge.
- The counter width is `$clog2(TimeoutCycles+1)`. It saturates and never wraps.

## Test plan
- Single requester, read: `req_i[1]`, addr 0x80001000, device answers rdata 0xDEADBEEF one cycle after grant. Required: `gnt_o[1]` in cycle 0, `rvalid_o[1]` in cycle 1 with rdata 0xDEADBEEF, err 0.
- Fairness: all 3 requesters request continuously for 6 transactions. Required: grant order 0,1,2,0,1,2, and no requester waits more than 2 transactions.
- Delayed grant: `bus_gnt_i` held low 4 cycles while `req_i[2]` rises in ADDR. Required: bus payload stays from the original winner, and the grant goes to that winner.
- Timeout: TimeoutCycles=8 and the device never sends rvalid. Required: `rvalid_o[sel]` with err=1 and rdata=0 exactly 8 cycles after the grant. A late `bus_rvalid_i` 3 cycles later produces no `rvalid_o`.
- Error passthrough: device returns `bus_err_i`=1. Required: `err_o`=1 on the same-cycle `rvalid_o`.
- Reset in RESP: deassert `rst_ni` mid-wait. Required: all outputs 0 asynchronously, then next arbitration starts at index 0.
